// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates the condition from ALU flags, registers the outcome, trains a
// direct-mapped 2-bit predictor table and counts mispredicts. Define BRU_UNSIGNED_COND_EN for LTU/GEU codes.
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [PC_W-1:0]  i_lk_pc,
    output logic             o_lk_taken,
    input  logic             i_res_valid,
    input  logic [2:0]       i_res_cond,
    input  logic             i_res_z,
    input  logic             i_res_n,
    input  logic             i_res_v,
    input  logic             i_res_c,
    input  logic [PC_W-1:0]  i_res_pc,
    input  logic             i_res_pred,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_out_valid,
    output logic             o_out_taken,
    output logic             o_out_mispredict,
    output logic [31:0]      o_compout,
    output logic [CNT_W-1:0] o_mp_count
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       r_table [DEPTH];
    logic             r_valid;
    logic             r_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_mp_count;

    logic             w_taken;
    logic             w_lt;
    logic             w_mispredict;
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_unused;

    assign w_lk_idx  = i_lk_pc[IDX_W+1:2];
    assign w_res_idx = i_res_pc[IDX_W+1:2];
    assign w_unused  = ^{i_lk_pc, i_res_pc, i_res_c};

    // Table read is the registered state, so a same-cycle update is never seen here.
    assign o_lk_taken = r_table[w_lk_idx][1];

    always_comb begin
        w_lt    = i_res_n ^ i_res_v;
        w_taken = 1'b0;
        case (i_res_cond)
            3'b000: w_taken = i_res_z;
            3'b001: w_taken = ~i_res_z;
            3'b010: w_taken = w_lt;
            3'b011: w_taken = ~w_lt;
            3'b100: w_taken = i_res_z | w_lt;
            3'b101: w_taken = ~i_res_z & ~w_lt;
`ifdef BRU_UNSIGNED_COND_EN
            3'b110: w_taken = ~i_res_c;
            3'b111: w_taken = i_res_c;
`else
            3'b110: w_taken = 1'b0;
            3'b111: w_taken = 1'b0;
`endif
            default: w_taken = 1'b0;
        endcase
        w_mispredict = w_taken != i_res_pred;
    end

    // Priority: reset, then flush, then stall, then accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_mp_count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 2'b01;
            end
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (i_stall) begin
            r_valid      <= r_valid;
        end else if (i_res_valid) begin
            r_valid      <= 1'b1;
            r_taken      <= w_taken;
            r_mispredict <= w_mispredict;
            if (w_taken) begin
                if (r_table[w_res_idx] != 2'b11) begin
                    r_table[w_res_idx] <= r_table[w_res_idx] + 2'd1;
                end
            end else begin
                if (r_table[w_res_idx] != 2'b00) begin
                    r_table[w_res_idx] <= r_table[w_res_idx] - 2'd1;
                end
            end
            if (w_mispredict && (r_mp_count != {CNT_W{1'b1}})) begin
                r_mp_count <= r_mp_count + CNT_W'(1);
            end
        end else begin
            r_valid      <= 1'b0;
        end
    end

    assign o_out_valid      = r_valid;
    assign o_out_taken      = r_taken;
    assign o_out_mispredict = r_mispredict;
    assign o_compout        = {31'b0, r_taken};
    assign o_mp_count       = r_mp_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit; flags come from a model ALU over random operands and
// the expected outcome from plain signed/unsigned comparisons of those operands.
module tb_branch_resolve_unit;

    localparam int PC_W    = 32;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 4;
    localparam int DEPTH   = 16;
    localparam int CNT_MAX = 15;

    logic             clk;
    logic             reset;
    logic [PC_W-1:0]  lkPc;
    logic             lkTaken;
    logic             resValid;
    logic [2:0]       resCond;
    logic             resZ, resN, resV, resC;
    logic [PC_W-1:0]  resPc;
    logic             resPred;
    logic             stall;
    logic             flush;
    logic             outValid;
    logic             outTaken;
    logic             outMispredict;
    logic [31:0]      compout;
    logic [CNT_W-1:0] mpCount;

    branch_resolve_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_lk_pc(lkPc), .o_lk_taken(lkTaken),
        .i_res_valid(resValid), .i_res_cond(resCond), .i_res_z(resZ), .i_res_n(resN),
        .i_res_v(resV), .i_res_c(resC), .i_res_pc(resPc), .i_res_pred(resPred),
        .i_stall(stall), .i_flush(flush), .o_out_valid(outValid), .o_out_taken(outTaken),
        .o_out_mispredict(outMispredict), .o_compout(compout), .o_mp_count(mpCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit taken;
        bit mp;
        int cnt;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   modelTbl [DEPTH];
    bit   mValid, mTaken, mMp;
    int   mCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idxOf(input bit [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit refTaken(input int cond, input bit [7:0] a, input bit [7:0] b);
        case (cond)
            0: return a == b;
            1: return a != b;
            2: return $signed(a) <  $signed(b);
            3: return $signed(a) >= $signed(b);
            4: return $signed(a) <= $signed(b);
            5: return $signed(a) >  $signed(b);
`ifdef BRU_UNSIGNED_COND_EN
            6: return a <  b;
            7: return a >= b;
`else
            6: return 1'b0;
            7: return 1'b0;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Model ALU: a - b as a + ~b + 1, yielding the four flags the branch sees.
    task automatic aluFlags(input bit [7:0] a, input bit [7:0] b);
        bit [8:0] s;
        s    = {1'b0, a} + {1'b0, ~b} + 9'd1;
        resC = s[8];
        resZ = (s[7:0] == 8'd0);
        resN = s[7];
        resV = (a[7] != b[7]) && (s[7] != a[7]);
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) modelTbl[i] = 1;
        mValid = 0; mTaken = 0; mMp = 0; mCnt = 0;
        expQ.delete();
    endtask

    task automatic doReset();
        reset    = 1'b1;
        resValid = 1'b1;
        resCond  = 3'b000;
        aluFlags(8'd3, 8'd3);
        resPc    = 32'h40;
        resPred  = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        resValid = 1'b0;
        modelReset();
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_mp_count", mpCount, 0);
        checkOutput("reset_compout", compout, 0);
        checkOutput("reset_mispredict", outMispredict, 0);
    endtask

    // One clock of stimulus; the lookup is checked against the pre-update table.
    task automatic applyStimulus(input bit valid, input int cond, input bit [7:0] a, input bit [7:0] b,
                                 input bit [31:0] pc, input bit pred, input bit st, input bit fl,
                                 input bit [31:0] lk);
        bit t;
        int ix;
        resValid = valid;
        resCond  = cond[2:0];
        aluFlags(a, b);
        resPc    = pc;
        resPred  = pred;
        stall    = st;
        flush    = fl;
        lkPc     = lk;
        #1;
        checkOutput("lk_taken_pre", lkTaken, modelTbl[idxOf(lk)] >= 2);
        if (fl) begin
            mValid = 0;
            mMp    = 0;
        end else if (st) begin
            mValid = mValid;
        end else if (valid) begin
            t      = refTaken(cond, a, b);
            mValid = 1;
            mTaken = t;
            mMp    = (t != pred);
            ix     = idxOf(pc);
            if (t) modelTbl[ix] = (modelTbl[ix] < 3) ? modelTbl[ix] + 1 : 3;
            else   modelTbl[ix] = (modelTbl[ix] > 0) ? modelTbl[ix] - 1 : 0;
            if (mMp && mCnt < CNT_MAX) mCnt++;
        end else begin
            mValid = 0;
        end
        if (mValid) expQ.push_back('{mTaken, mMp, mCnt});
        @(posedge clk);
        #1;
        checkOutput("out_valid", outValid, mValid);
        checkOutput("mp_count", mpCount, mCnt);
    endtask

    task automatic checkLookup(input string name, input bit [31:0] pc);
        lkPc = pc;
        #1;
        checkOutput(name, lkTaken, modelTbl[idxOf(pc)] >= 2);
    endtask

    // Monitor: every presented resolution must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && outValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_taken", outTaken, e.taken);
                checkOutput("sb_mispredict", outMispredict, e.mp);
                checkOutput("sb_compout", compout, {31'b0, e.taken});
                checkOutput("sb_mp_count", mpCount, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [7:0]  a, b;
        bit [31:0] pc;
        reset = 1'b0; lkPc = '0; resValid = 1'b0; resCond = '0; resZ = 0; resN = 0; resV = 0; resC = 0;
        resPc = '0; resPred = 1'b0; stall = 1'b0; flush = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        for (int i = 0; i < DEPTH; i++) checkLookup("lookup_after_reset", (32'(i) << 2) | 32'h0000_0f03);

        // EQ taken, predicted not taken: mispredict, entry 0 goes weakly taken.
        applyStimulus(1, 0, 8'd5, 8'd5, 32'h40, 0, 0, 0, 32'h40);
        applyStimulus(0, 0, 8'd0, 8'd0, 32'h0, 0, 0, 0, 32'h40);
        checkOutput("idx0_weakly_taken", lkTaken, 1);

        // Repeated taken branches saturate the entry for 0x44.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'd9, 8'd9, 32'h44, 1, 0, 0, 32'h44);
        checkLookup("idx1_saturated", 32'h44);

        applyStimulus(1, 5, 8'h7f, 8'hff, 32'h48, 0, 0, 0, 32'h48);
        applyStimulus(1, 4, 8'd1, 8'd2, 32'h4c, 1, 0, 0, 32'h48);
        applyStimulus(1, 3, 8'd1, 8'd2, 32'h50, 1, 0, 0, 32'h4c);

        // Stall holds everything, then flush kills the branch without training.
        applyStimulus(1, 0, 8'd1, 8'd1, 32'h54, 0, 1, 0, 32'h54);
        applyStimulus(1, 0, 8'd1, 8'd1, 32'h54, 0, 1, 1, 32'h54);
        checkOutput("flush_mispredict_cleared", outMispredict, 0);
        checkLookup("flush_no_train", 32'h54);

        applyStimulus(1, 6, 8'd1, 8'd2, 32'h58, 0, 0, 0, 32'h58);
        applyStimulus(1, 7, 8'd2, 8'd1, 32'h5c, 1, 0, 0, 32'h58);

        // Randomized traffic with stalls, flushes and same-index lookups.
        for (int i = 0; i < 300; i++) begin
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            pc = $urandom;
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 7), a, b, pc, 1'($urandom),
                          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                          $urandom_range(0, 1) ? pc : $urandom);
        end

        // Mid-stream reset discards the accept in the reset cycle.
        doReset();
        for (int i = 0; i < DEPTH; i++) checkLookup("lookup_after_rereset", 32'(i) << 2);

        // Counter saturation with a stream of mispredicts.
        for (int i = 0; i < CNT_MAX + 5; i++) applyStimulus(1, 1, 8'd4, 8'd4, 32'h100, 1, 0, 0, 32'h100);
        checkOutput("mp_count_saturated", mpCount, CNT_MAX);

        applyStimulus(0, 0, 8'd0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 8'd0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
